// File: rtl/mux_arb_pkg.sv
// Shared types, sizes and arbitration helpers for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } arb_t;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = {SEL_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            idx = idx | (oh[k] ? SEL_W'(k) : {SEL_W{1'b0}});
        end
        return idx;
    endfunction

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Walk from the farthest offset down so the nearest requester to ptr wins.
    function automatic arb_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
        arb_t             res;
        logic [SEL_W-1:0] idx;
        res.found = 1'b0;
        res.idx   = {SEL_W{1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_4x1_using_2_2x1.sv
// Gate-level 4:1 mux built from two levels of 2:1 and-or selectors.
module mux_4x1_using_2_2x1 (
    output logic       Y,
    input  logic [3:0] I,
    input  logic [1:0] S
);

    logic lo_s;
    logic hi_s;

    assign lo_s = (I[0] & ~S[0]) | (I[1] & S[0]);
    assign hi_s = (I[2] & ~S[0]) | (I[3] & S[0]);
    assign Y    = (lo_s & ~S[1]) | (hi_s & S[1]);

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux; define MUX_ARB_BURST_LIMIT_EN to cap
// consecutive grant cycles per owner at BURST_MAX.
module mux_4x1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] I,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] S,
    output logic             Y,
    output logic             valid
);

    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

    state_t           state_r;
    state_t           state_s;
    logic [N_REQ-1:0] gnt_r;
    logic [N_REQ-1:0] gnt_s;
    logic [SEL_W-1:0] sel_r;
    logic [SEL_W-1:0] sel_s;
    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] ptr_s;
    logic             valid_r;
    logic             valid_s;
    logic [SEL_W-1:0] owner_s;
    logic [N_REQ-1:0] others_s;
    arb_t             win_all_s;
    arb_t             win_oth_s;
    logic             take_s;
    logic [SEL_W-1:0] take_idx_s;
    logic             y_raw_s;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_s;

    // The pointer already sits just past the owner, so the excluded search still starts at ptr.
    assign owner_s   = onehot_to_idx(gnt_r);
    assign others_s  = req & ~gnt_r;
    assign win_all_s = rr_pick(req, ptr_r);
    assign win_oth_s = rr_pick(others_s, ptr_r);

    // Next-state decision: who owns the mux after this edge.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        sel_s      = sel_r;
        ptr_s      = ptr_r;
        valid_s    = valid_r;
        cnt_s      = cnt_r;
        take_s     = 1'b0;
        take_idx_s = {SEL_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (win_all_s.found) begin
                    take_s     = 1'b1;
                    take_idx_s = win_all_s.idx;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (req[owner_s]) begin
`ifdef MUX_ARB_BURST_LIMIT_EN
                    if ((cnt_r == BURST_LAST) && win_oth_s.found) begin
                        take_s     = 1'b1;
                        take_idx_s = win_oth_s.idx;
                    end else if (cnt_r != BURST_LAST) begin
                        cnt_s = cnt_r + 4'd1;
                    end else begin
                        cnt_s = cnt_r;
                    end
`else
                    state_s = GRANT;
`endif
                end else if (win_oth_s.found) begin
                    take_s     = 1'b1;
                    take_idx_s = win_oth_s.idx;
                end else begin
                    state_s = IDLE;
                    gnt_s   = {N_REQ{1'b0}};
                    valid_s = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = {N_REQ{1'b0}};
                valid_s = 1'b0;
            end
        endcase
        if (take_s) begin
            state_s = GRANT;
            gnt_s   = idx_to_onehot(take_idx_s);
            sel_s   = take_idx_s;
            ptr_s   = take_idx_s + 2'd1;
            valid_s = 1'b1;
            cnt_s   = 4'd0;
        end else begin
            ptr_s = ptr_r;
        end
    end

    // Arbiter state, grant, select and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            gnt_r   <= {N_REQ{1'b0}};
            sel_r   <= {SEL_W{1'b0}};
            ptr_r   <= {SEL_W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            ptr_r   <= ptr_s;
            valid_r <= valid_s;
        end
    end

`ifdef MUX_ARB_BURST_LIMIT_EN
    // Consecutive-hold counter for the current owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else begin
            cnt_r <= cnt_s;
        end
    end
`else
    logic unused_burst_s;
    assign cnt_r          = 4'd0;
    assign unused_burst_s = ^{BURST_LAST, cnt_s};
`endif

    mux_4x1_using_2_2x1 u_mux (
        .Y (y_raw_s),
        .I (I),
        .S (sel_r)
    );

    assign gnt   = gnt_r;
    assign S     = sel_r;
    assign valid = valid_r;
    assign Y     = y_raw_s & valid_r;

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Directed self-checking bench for mux_4x1_rr_arbiter with an integer ownership model.
module tb_mux_4x1_rr_arbiter;

    localparam int BURST_MAX = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] I = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] S;
    logic       Y;
    logic       valid;

    int n_vec = 0;
    int n_err = 0;

    // Model: owner index (-1 idle), priority pointer, last select, hold count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_cnt   = 0;

    mux_4x1_rr_arbiter #(.BURST_MAX(BURST_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .I     (I),
        .gnt   (gnt),
        .S     (S),
        .Y     (Y),
        .valid (valid)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int p, input int excl);
        int c;
        for (int k = 0; k < 4; k++) begin
            c = (p + k) % 4;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        m_owner = w;
        m_sel   = w;
        m_ptr   = (w + 1) % 4;
        m_cnt   = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_sel   = 0;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            w = pick(req, m_ptr, -1);
            if (w >= 0) model_grant(w);
        end else if (req[m_owner]) begin
`ifdef MUX_ARB_BURST_LIMIT_EN
            w = pick(req, m_ptr, m_owner);
            if (m_cnt == BURST_MAX - 1 && w >= 0) model_grant(w);
            else if (m_cnt < BURST_MAX - 1) m_cnt++;
`endif
        end else begin
            w = pick(req, m_ptr, m_owner);
            if (w >= 0) model_grant(w);
            else m_owner = -1;
        end
    end

    always @(posedge clk) begin
        logic [3:0] e_gnt;
        logic       e_valid;
        logic       e_y;
        #1;
        e_gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e_valid = (m_owner >= 0);
        e_y     = e_valid & I[m_sel];
        n_vec++;
        if (gnt !== e_gnt) begin
            n_err++;
            $display("FAIL model_gnt t=%0t: got %b expected %b", $time, gnt, e_gnt);
        end
        if (S !== 2'(m_sel)) begin
            n_err++;
            $display("FAIL model_S t=%0t: got %0d expected %0d", $time, S, m_sel);
        end
        if (valid !== e_valid) begin
            n_err++;
            $display("FAIL model_valid t=%0t: got %b expected %b", $time, valid, e_valid);
        end
        if (Y !== e_y) begin
            n_err++;
            $display("FAIL model_Y t=%0t: got %b expected %b", $time, Y, e_y);
        end
    end

    task automatic lit(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] i);
        @(negedge clk);
        req = r;
        I   = i;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        I     = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] rot_req [9] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                                4'b1111, 4'b1011, 4'b1111, 4'b0111};
    logic [3:0] rot_gnt [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                4'b0100, 4'b1000, 4'b1000, 4'b0001};

    initial begin
        logic [3:0] e;

        // Reset held with every requester asking.
        req = 4'b1111;
        I   = 4'b1111;
        repeat (2) @(posedge clk);
        #2;
        lit("rst_gnt", gnt, 4'b0000);
        lit("rst_S", {2'b00, S}, 4'b0000);
        lit("rst_valid", {3'b000, valid}, 4'b0000);
        lit("rst_Y", {3'b000, Y}, 4'b0000);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;
        step(4'b1010, 4'b0000);
        lit("first_gnt", gnt, 4'b0010);
        lit("first_S", {2'b00, S}, 4'b0001);

        // Fair rotation with one-cycle drops.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(rot_req[k], 4'b0000);
            lit("rotate_gnt", gnt, rot_gnt[k]);
            lit("rotate_valid", {3'b000, valid}, 4'b0001);
        end

        // Release to idle, then pointer sits at 2 after granting 1.
        do_reset();
        step(4'b0100, 4'b0000);
        lit("rel_gnt", gnt, 4'b0100);
        step(4'b0000, 4'b0000);
        lit("rel_valid", {3'b000, valid}, 4'b0000);
        lit("rel_S_kept", {2'b00, S}, 4'b0010);
        step(4'b0010, 4'b0000);
        lit("rel_next_gnt", gnt, 4'b0010);
        step(4'b1101, 4'b0000);
        lit("rel_ptr2_gnt", gnt, 4'b0100);

        // Data path on index 3, then masked while idle.
        do_reset();
        step(4'b1000, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            step(4'b1000, 4'b1000);
            lit("dp_Y_hi", {3'b000, Y}, 4'b0001);
            step(4'b1000, 4'b0000);
            lit("dp_Y_lo", {3'b000, Y}, 4'b0000);
        end
        step(4'b0000, 4'b1111);
        lit("dp_Y_idle", {3'b000, Y}, 4'b0000);
        lit("dp_S_idle", {2'b00, S}, 4'b0011);

        // Two contenders: burst-limited alternation or indefinite hold.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step(4'b0011, 4'b0000);
`ifdef MUX_ARB_BURST_LIMIT_EN
            e = ((k / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
            e = 4'b0001;
`endif
            lit("burst_gnt", gnt, e);
        end
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(4'b0001, 4'b0000);
            lit("solo_hold_gnt", gnt, 4'b0001);
        end

        // Asynchronous reset between edges while index 2 owns the mux.
        do_reset();
        step(4'b0100, 4'b0100);
        lit("ar_pre_gnt", gnt, 4'b0100);
        lit("ar_pre_Y", {3'b000, Y}, 4'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        lit("ar_gnt", gnt, 4'b0000);
        lit("ar_valid", {3'b000, valid}, 4'b0000);
        lit("ar_Y", {3'b000, Y}, 4'b0000);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;
        step(4'b1111, 4'b0000);
        lit("ar_restart_gnt", gnt, 4'b0001);

        step(4'b0000, 4'b0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_4x1_rr_arbiter.md
# mux_4x1_rr_arbiter

Round-robin arbiter that shares one 4:1 gate-level mux between four single-bit requesters. It drives the mux select from a registered one-hot grant and holds ownership while the owner keeps requesting. It rotates priority fairly and gates the mux output with a valid flag. It sits directly in front of the 4:1 mux datapath and is the only source of its select lines.

## Interface
Parameters:
- BURST_MAX, 4, maximum consecutive grant cycles per owner when the burst-limit feature is compiled in (legal 2..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; req[k] high means requester k wants the mux.
- I  input  4  mux data inputs; I[k] belongs to requester k.
- gnt  output  4  registered one-hot grant; all-zero when idle.
- S  output  2  registered mux select, equal to the encoded index of gnt.
- Y  output  1  combinational I[S] AND valid.
- valid  output  1  registered; high when any gnt bit is high.

## Operation
- Two states: IDLE (gnt=0) and GRANT (exactly one gnt bit set).
- Rotating pointer ptr[1:0]: the highest-priority index for the next arbitration.
- Arbitration picks the first k with req[k]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - Any req high: arbitrate. Next state is GRANT, gnt/S take the winner, ptr becomes winner+1 mod 4.
  - No req: stay IDLE.
- GRANT, owner o=S:
  - req[o]=1: hold the grant (subject to the burst limit).
  - req[o]=0: re-arbitrate on the same edge, excluding o. If another requester wins, hand off directly with no idle cycle and set ptr=winner+1. If none wins, go to IDLE with gnt=0; S keeps its last value and ptr is unchanged.
- Y is forced to 0 whenever valid=0.
- A req bit rising while another requester owns the mux has no effect until the next arbitration.

## Timing
- Reset (async assert, sync-to-clk release is the integrator's job): gnt=0, S=0, valid=0, ptr=0, burst count=0, state IDLE. Y=0 follows.
- Request-to-grant latency is 1 cycle: req sampled high at edge n in IDLE gives gnt/valid high after edge n.
- Handoff latency is 0 idle cycles: the owner's req sampled low at edge n gives the new owner's gnt after edge n.
- Release: if no other req is pending, valid drops after the same edge.
- Y follows I combinationally within the granted cycle (mux path only, no register).
- Reset asserted mid-grant clears all outputs immediately, without waiting for clk. The first grant after reset searches from index 0.
- Simultaneous requests are resolved by ptr only. Lower index never wins by default.

## Configuration
- MUX_ARB_BURST_LIMIT_EN defined:
  - A 4-bit counter clears on every new grant and increments each cycle the same owner holds.
  - When it reaches BURST_MAX-1 and any other req is high, the arbiter re-arbitrates excluding the owner and hands off on that edge.
  - If no other req is high, the owner keeps the grant and the counter saturates at BURST_MAX-1.
- Undefined: no counter is built; the owner holds the grant until its req drops, so one requester can hold the mux indefinitely.

## Structure
- Package mux_arb_pkg:
  - state enum (IDLE, GRANT)
  - N_REQ=4
  - SEL_W=2
  - the one-hot-to-index and rotate-priority helper functions
- One natural sub-module: the existing gate-level mux_4x1_using_2_2x1, instantiated with (Y_raw, I, S). Y = Y_raw & valid.
- The arbiter FSM, pointer and burst counter live in the top module.

## Test plan
- Reset check: rst_n=0 while req=4'b1111 → gnt=0, S=0, valid=0, Y=0. Release, then req=4'b1010 → after 1 edge gnt=4'b0010, S=1.
- Fair rotation: req held at 4'b1111, each owner drops req for one cycle after 2 cycles of ownership → grant order 0,1,2,3,0 with no idle cycle between owners.
- Release to idle: only req[2] high, then dropped → valid goes low on the edge that samples the drop. The next req[1] gets gnt=4'b0010 one cycle later and ptr=2.
- Data path: grant held on index 3, I toggling 4'b1000/4'b0000 → Y toggles 1/0 in the same cycles. With the grant idle and I=4'b1111 → Y=0.
- Burst limit (MUX_ARB_BURST_LIMIT_EN, BURST_MAX=4): req[0] and req[1] held high → gnt alternates 4 cycles on 0 and 4 cycles on 1. With only req[0] high it holds indefinitely. Without the macro, req[0] holds while req[1] waits forever.
- Async reset mid-grant: assert rst_n low between clock edges while gnt=4'b0100 → gnt, valid and Y clear immediately. After release, arbitration restarts from index 0.
